// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst slave over a dual-port 32-bit RAM with independent write and read burst engines.
// Read data appears two cycles after AR; every output holds while its ready is low.
module axi4_burst_mem_slave #(
  parameter int C_S00_AXI_ID_WIDTH     = 1,
  parameter int C_S00_AXI_DATA_WIDTH   = 32,
  parameter int C_S00_AXI_ADDR_WIDTH   = 13,
  parameter int C_S00_AXI_AWUSER_WIDTH = 1,
  parameter int C_S00_AXI_ARUSER_WIDTH = 1,
  parameter int C_S00_AXI_WUSER_WIDTH  = 1,
  parameter int C_S00_AXI_RUSER_WIDTH  = 1,
  parameter int C_S00_AXI_BUSER_WIDTH  = 1
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_awid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [7:0]                        s00_axi_awlen,
  input  logic [2:0]                        s00_axi_awsize,
  input  logic [1:0]                        s00_axi_awburst,
  input  logic                              s00_axi_awlock,
  input  logic [3:0]                        s00_axi_awcache,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic [3:0]                        s00_axi_awqos,
  input  logic [3:0]                        s00_axi_awregion,
  input  logic [C_S00_AXI_AWUSER_WIDTH-1:0] s00_axi_awuser,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wlast,
  input  logic [C_S00_AXI_WUSER_WIDTH-1:0]  s00_axi_wuser,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_bid,
  output logic [1:0]                        s00_axi_bresp,
  output logic [C_S00_AXI_BUSER_WIDTH-1:0]  s00_axi_buser,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]                        s00_axi_arlen,
  input  logic [2:0]                        s00_axi_arsize,
  input  logic [1:0]                        s00_axi_arburst,
  input  logic                              s00_axi_arlock,
  input  logic [3:0]                        s00_axi_arcache,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic [3:0]                        s00_axi_arqos,
  input  logic [3:0]                        s00_axi_arregion,
  input  logic [C_S00_AXI_ARUSER_WIDTH-1:0] s00_axi_aruser,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]     s00_axi_rid,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rlast,
  output logic [C_S00_AXI_RUSER_WIDTH-1:0]  s00_axi_ruser,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready
);
  localparam int IW    = C_S00_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;
  localparam int NB    = C_S00_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [C_S00_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  // WRAP assumes legal AXI wrap lengths (2/4/8/16 beats), so len is the in-window mask.
  function automatic logic [IW-1:0] next_addr(input logic [IW-1:0] a, input logic [3:0] len,
                                              input logic [1:0] burst);
    logic [IW-1:0] mask;
    mask = {{(IW-4){1'b0}}, len};
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + IW'(1)) & mask);
      default: next_addr = a + IW'(1);
    endcase
  endfunction

  w_state_t w_state, w_next;
  logic [IW-1:0] w_addr;
  logic [7:0]    w_len, w_cnt;
  logic [1:0]    w_burst;
  logic          aw_hs, w_hs, b_hs;

  assign aw_hs = s00_axi_awvalid & s00_axi_awready;
  assign w_hs  = s00_axi_wvalid & s00_axi_wready;
  assign b_hs  = s00_axi_bvalid & s00_axi_bready;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) w_state <= W_IDLE;
    else                  w_state <= w_next;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_cnt == w_len) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Ready/valid flags are registered from the next state so they read 0 throughout reset.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bid     <= '0;
      w_addr          <= '0;
      w_len           <= '0;
      w_cnt           <= '0;
      w_burst         <= '0;
    end else begin
      s00_axi_awready <= (w_next == W_IDLE);
      s00_axi_wready  <= (w_next == W_DATA);
      s00_axi_bvalid  <= (w_next == W_RESP);
      if (aw_hs) begin
        s00_axi_bid <= s00_axi_awid;
        w_addr      <= s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
        w_len       <= s00_axi_awlen;
        w_burst     <= s00_axi_awburst;
        w_cnt       <= '0;
      end else if (w_hs) begin
        w_addr <= next_addr(w_addr, w_len[3:0], w_burst);
        w_cnt  <= w_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk)
    if (w_hs)
      for (int b = 0; b < NB; b++)
        if (s00_axi_wstrb[b]) mem[w_addr][8*b +: 8] <= s00_axi_wdata[8*b +: 8];

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_buser = '0;

  r_state_t r_state, r_next;
  logic [IW-1:0] r_addr;
  logic [7:0]    r_len, r_cnt;
  logic [1:0]    r_burst;
  logic          r_prime, ar_hs, r_hs;

  assign ar_hs = s00_axi_arvalid & s00_axi_arready;
  assign r_hs  = s00_axi_rvalid & s00_axi_rready;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) r_state <= R_IDLE;
    else                  r_state <= r_next;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && s00_axi_rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // r_prime issues the first RAM read the cycle after AR; later reads fire on each accepted beat.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rlast   <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rid     <= '0;
      r_addr          <= '0;
      r_len           <= '0;
      r_cnt           <= '0;
      r_burst         <= '0;
      r_prime         <= 1'b0;
    end else begin
      s00_axi_arready <= (r_next == R_IDLE);
      if (ar_hs) begin
        s00_axi_rid <= s00_axi_arid;
        r_addr      <= s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
        r_len       <= s00_axi_arlen;
        r_burst     <= s00_axi_arburst;
        r_prime     <= 1'b1;
      end else if (r_prime || r_hs) begin
        if (r_hs && s00_axi_rlast) begin
          s00_axi_rvalid <= 1'b0;
          s00_axi_rlast  <= 1'b0;
        end else begin
          s00_axi_rdata  <= mem[r_addr];
          s00_axi_rvalid <= 1'b1;
          r_addr         <= next_addr(r_addr, r_len[3:0], r_burst);
          r_cnt          <= r_prime ? 8'd0 : r_cnt + 8'd1;
          s00_axi_rlast  <= r_prime ? (r_len == 8'd0) : (r_cnt + 8'd1 == r_len);
          r_prime        <= 1'b0;
        end
      end
    end
  end

  assign s00_axi_rresp = 2'b00;
  assign s00_axi_ruser = '0;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awaddr[1:0], s00_axi_awsize, s00_axi_awlock, s00_axi_awcache,
                       s00_axi_awprot, s00_axi_awqos, s00_axi_awregion, s00_axi_awuser,
                       s00_axi_wlast, s00_axi_wuser, s00_axi_araddr[1:0], s00_axi_arsize,
                       s00_axi_arlock, s00_axi_arcache, s00_axi_arprot, s00_axi_arqos,
                       s00_axi_arregion, s00_axi_aruser};
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench: a reference memory model feeds an expected-read queue checked beat by beat.
module tb_axi4_burst_mem_slave;
  logic        s00_axi_aclk, s00_axi_aresetn;
  logic [0:0]  s00_axi_awid, s00_axi_bid, s00_axi_arid, s00_axi_rid;
  logic [12:0] s00_axi_awaddr, s00_axi_araddr;
  logic [7:0]  s00_axi_awlen, s00_axi_arlen;
  logic [2:0]  s00_axi_awsize, s00_axi_arsize, s00_axi_awprot, s00_axi_arprot;
  logic [1:0]  s00_axi_awburst, s00_axi_arburst, s00_axi_bresp, s00_axi_rresp;
  logic        s00_axi_awlock, s00_axi_arlock;
  logic [3:0]  s00_axi_awcache, s00_axi_awqos, s00_axi_awregion;
  logic [3:0]  s00_axi_arcache, s00_axi_arqos, s00_axi_arregion;
  logic [0:0]  s00_axi_awuser, s00_axi_aruser, s00_axi_wuser, s00_axi_ruser, s00_axi_buser;
  logic        s00_axi_awvalid, s00_axi_awready, s00_axi_wvalid, s00_axi_wready;
  logic [31:0] s00_axi_wdata, s00_axi_rdata;
  logic [3:0]  s00_axi_wstrb;
  logic        s00_axi_wlast, s00_axi_bvalid, s00_axi_bready;
  logic        s00_axi_arvalid, s00_axi_arready, s00_axi_rlast, s00_axi_rvalid, s00_axi_rready;

  int vecs = 0;
  int errs = 0;
  logic [31:0] model [2048];
  logic [31:0] exp_q [$];

  axi4_burst_mem_slave dut (
    .s00_axi_aclk(s00_axi_aclk), .s00_axi_aresetn(s00_axi_aresetn),
    .s00_axi_awid(s00_axi_awid), .s00_axi_awaddr(s00_axi_awaddr), .s00_axi_awlen(s00_axi_awlen),
    .s00_axi_awsize(s00_axi_awsize), .s00_axi_awburst(s00_axi_awburst),
    .s00_axi_awlock(s00_axi_awlock), .s00_axi_awcache(s00_axi_awcache),
    .s00_axi_awprot(s00_axi_awprot), .s00_axi_awqos(s00_axi_awqos),
    .s00_axi_awregion(s00_axi_awregion), .s00_axi_awuser(s00_axi_awuser),
    .s00_axi_awvalid(s00_axi_awvalid), .s00_axi_awready(s00_axi_awready),
    .s00_axi_wdata(s00_axi_wdata), .s00_axi_wstrb(s00_axi_wstrb), .s00_axi_wlast(s00_axi_wlast),
    .s00_axi_wuser(s00_axi_wuser), .s00_axi_wvalid(s00_axi_wvalid), .s00_axi_wready(s00_axi_wready),
    .s00_axi_bid(s00_axi_bid), .s00_axi_bresp(s00_axi_bresp), .s00_axi_buser(s00_axi_buser),
    .s00_axi_bvalid(s00_axi_bvalid), .s00_axi_bready(s00_axi_bready),
    .s00_axi_arid(s00_axi_arid), .s00_axi_araddr(s00_axi_araddr), .s00_axi_arlen(s00_axi_arlen),
    .s00_axi_arsize(s00_axi_arsize), .s00_axi_arburst(s00_axi_arburst),
    .s00_axi_arlock(s00_axi_arlock), .s00_axi_arcache(s00_axi_arcache),
    .s00_axi_arprot(s00_axi_arprot), .s00_axi_arqos(s00_axi_arqos),
    .s00_axi_arregion(s00_axi_arregion), .s00_axi_aruser(s00_axi_aruser),
    .s00_axi_arvalid(s00_axi_arvalid), .s00_axi_arready(s00_axi_arready),
    .s00_axi_rid(s00_axi_rid), .s00_axi_rdata(s00_axi_rdata), .s00_axi_rresp(s00_axi_rresp),
    .s00_axi_rlast(s00_axi_rlast), .s00_axi_ruser(s00_axi_ruser),
    .s00_axi_rvalid(s00_axi_rvalid), .s00_axi_rready(s00_axi_rready)
  );

  initial begin
    s00_axi_aclk = 1'b0;
    forever #5 s00_axi_aclk = ~s00_axi_aclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int beat_word(input int start, input int len, input logic [1:0] burst,
                                   input int i);
    int win, base;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) begin
      win  = len + 1;
      base = (start / win) * win;
      return base + ((start - base + i) % win);
    end
    return (start + i) % 2048;
  endfunction

  task automatic clk_step();
    @(posedge s00_axi_aclk);
    #1;
  endtask

  task automatic wr(input logic [12:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input logic id, input logic [31:0] d0, input logic [31:0] step,
                    input logic [3:0] strb);
    int n, w;
    logic [31:0] d;
    s00_axi_awid = id; s00_axi_awaddr = addr; s00_axi_awlen = len; s00_axi_awburst = burst;
    s00_axi_awvalid = 1'b1;
    s00_axi_wvalid = 1'b1; s00_axi_wdata = d0; s00_axi_wstrb = strb;
    check("wready_holdoff", 32'(s00_axi_wready), 0);
    n = 0;
    while (!s00_axi_awready && n < 50) begin clk_step(); n++; end
    check("awready", 32'(s00_axi_awready), 1);
    clk_step();
    s00_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      d = d0 + step * 32'(i);
      s00_axi_wdata = d;
      n = 0;
      while (!s00_axi_wready && n < 20) begin clk_step(); n++; end
      check("wready_beat", 32'(s00_axi_wready), 1);
      w = beat_word(int'(addr >> 2), int'(len), burst, i);
      for (int b = 0; b < 4; b++) if (strb[b]) model[w][8*b +: 8] = d[8*b +: 8];
      clk_step();
    end
    s00_axi_wvalid = 1'b0;
    check("wready_drop", 32'(s00_axi_wready), 0);
    check("bvalid", 32'(s00_axi_bvalid), 1);
    check("bid", 32'(s00_axi_bid), 32'(id));
    check("bresp", 32'(s00_axi_bresp), 0);
    check("buser", 32'(s00_axi_buser), 0);
    check("awready_resp", 32'(s00_axi_awready), 0);
    clk_step();
    check("bvalid_hold", 32'(s00_axi_bvalid), 1);
    check("awready_hold", 32'(s00_axi_awready), 0);
    s00_axi_bready = 1'b1;
    clk_step();
    s00_axi_bready = 1'b0;
    check("bvalid_clr", 32'(s00_axi_bvalid), 0);
    check("awready_ret", 32'(s00_axi_awready), 1);
  endtask

  task automatic rd(input logic [12:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input logic id, input bit toggle);
    int n, beat, cyc;
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back(model[beat_word(int'(addr >> 2), int'(len), burst, i)]);
    s00_axi_arid = id; s00_axi_araddr = addr; s00_axi_arlen = len; s00_axi_arburst = burst;
    s00_axi_arvalid = 1'b1;
    n = 0;
    while (!s00_axi_arready && n < 50) begin clk_step(); n++; end
    check("arready", 32'(s00_axi_arready), 1);
    clk_step();
    s00_axi_arvalid = 1'b0;
    check("rvalid_lat0", 32'(s00_axi_rvalid), 0);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      s00_axi_rready = toggle ? cyc[0] : 1'b1;
      if (cyc == 1) check("rvalid_lat1", 32'(s00_axi_rvalid), 1);
      if (s00_axi_rvalid) begin
        check("rdata", s00_axi_rdata, exp_q.size() > 0 ? exp_q[0] : 32'hDEAD_BEEF);
        check("rlast", 32'(s00_axi_rlast), 32'(beat == int'(len)));
        check("rid", 32'(s00_axi_rid), 32'(id));
        check("rresp", 32'(s00_axi_rresp), 0);
        if (s00_axi_rready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          beat++;
        end
      end
      clk_step();
      cyc++;
    end
    s00_axi_rready = 1'b0;
    check("r_beats", 32'(beat), 32'(int'(len) + 1));
    check("rvalid_end", 32'(s00_axi_rvalid), 0);
    check("arready_ret", 32'(s00_axi_arready), 1);
  endtask

  initial begin
    s00_axi_aresetn = 1'b0;
    s00_axi_awid = '0; s00_axi_awaddr = '0; s00_axi_awlen = '0; s00_axi_awsize = 3'd2;
    s00_axi_awburst = 2'b01; s00_axi_awlock = 1'b0; s00_axi_awcache = '0; s00_axi_awprot = '0;
    s00_axi_awqos = '0; s00_axi_awregion = '0; s00_axi_awuser = '0; s00_axi_awvalid = 1'b0;
    s00_axi_wdata = '0; s00_axi_wstrb = '0; s00_axi_wlast = 1'b0; s00_axi_wuser = '0;
    s00_axi_wvalid = 1'b0; s00_axi_bready = 1'b0;
    s00_axi_arid = '0; s00_axi_araddr = '0; s00_axi_arlen = '0; s00_axi_arsize = 3'd2;
    s00_axi_arburst = 2'b01; s00_axi_arlock = 1'b0; s00_axi_arcache = '0; s00_axi_arprot = '0;
    s00_axi_arqos = '0; s00_axi_arregion = '0; s00_axi_aruser = '0; s00_axi_arvalid = 1'b0;
    s00_axi_rready = 1'b0;

    #1;
    check("rst_awready", 32'(s00_axi_awready), 0);
    check("rst_arready", 32'(s00_axi_arready), 0);
    check("rst_wready", 32'(s00_axi_wready), 0);
    check("rst_bvalid", 32'(s00_axi_bvalid), 0);
    check("rst_rvalid", 32'(s00_axi_rvalid), 0);
    check("rst_rlast", 32'(s00_axi_rlast), 0);
    check("rst_rdata", s00_axi_rdata, 0);
    #1 s00_axi_aresetn = 1'b1;
    clk_step();
    check("post_rst_awready", 32'(s00_axi_awready), 1);
    check("post_rst_arready", 32'(s00_axi_arready), 1);

    wr(13'h0003, 8'd7, 2'b01, 1'b0, 32'h1234_5678, 32'd0, 4'hF);
    rd(13'h0000, 8'd7, 2'b01, 1'b0, 1'b0);

    wr(13'h0000, 8'd0, 2'b01, 1'b1, 32'hAABB_CCDD, 32'd0, 4'b0011);
    check("strb_model", model[0], 32'h1234_CCDD);
    rd(13'h0000, 8'd7, 2'b01, 1'b1, 1'b1);

    wr(13'h1FFC, 8'd1, 2'b01, 1'b0, 32'hC0DE_0000, 32'd1, 4'hF);
    rd(13'h1FFC, 8'd1, 2'b01, 1'b0, 1'b0);

    wr(13'h0008, 8'd3, 2'b10, 1'b1, 32'h0000_00A0, 32'd1, 4'hF);
    rd(13'h0000, 8'd3, 2'b01, 1'b0, 1'b1);
    rd(13'h0008, 8'd3, 2'b10, 1'b1, 1'b0);

    wr(13'h0040, 8'd2, 2'b00, 1'b0, 32'h0000_00D0, 32'd1, 4'hF);
    rd(13'h0040, 8'd0, 2'b01, 1'b0, 1'b0);
    rd(13'h0010, 8'd1, 2'b11, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/axi4_burst_mem_slave.md
Name: axi4_burst_mem_slave

Overview:
- AXI4 (full, burst-capable) slave wrapper around an on-chip 32-bit RAM: 2^(C_S00_AXI_ADDR_WIDTH) bytes, 8 KB at default.
- Sits on an interconnect master port as a memory-mapped scratch buffer.
- Write and read channels are independent. A dual-port memory lets one write burst and one read burst proceed concurrently.

Parameters:
- C_S00_AXI_ID_WIDTH, 1: width of awid/bid/arid/rid.
- C_S00_AXI_DATA_WIDTH, 32: data bus width. Only 32 is supported.
- C_S00_AXI_ADDR_WIDTH, 13: byte address width. Memory depth is 2^(ADDR_WIDTH-2) words (2048 at default).
- C_S00_AXI_AWUSER_WIDTH / ARUSER / WUSER / RUSER / BUSER_WIDTH, 1 each: user sideband widths.

Ports:
- s00_axi_aclk  in  1  single clock; all logic on rising edge.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- s00_axi_awid / s00_axi_awaddr  in  ID / ADDR  write burst ID, start byte address.
- s00_axi_awlen / s00_axi_awsize / s00_axi_awburst  in  8/3/2  beats-1, beat size (ignored), burst type.
- s00_axi_awlock / awcache / awprot / awqos / awregion / awuser  in  1/4/3/4/4/AWUSER  accepted, ignored.
- s00_axi_awvalid  in  1;  s00_axi_awready  out  1  write address handshake.
- s00_axi_wdata / s00_axi_wstrb  in  DATA / DATA/8  write data, byte enables.
- s00_axi_wlast / s00_axi_wuser  in  1 / WUSER  ignored (beat count ends the burst).
- s00_axi_wvalid  in  1;  s00_axi_wready  out  1  write data handshake.
- s00_axi_bid / s00_axi_bresp / s00_axi_buser  out  ID/2/BUSER  write response: awid, 2'b00, zero.
- s00_axi_bvalid  out  1;  s00_axi_bready  in  1  response handshake.
- s00_axi_arid / araddr / arlen / arsize / arburst  in  ID/ADDR/8/3/2  read burst attributes (arsize ignored).
- s00_axi_arlock / arcache / arprot / arqos / arregion / aruser  in  1/4/3/4/4/ARUSER  ignored.
- s00_axi_arvalid  in  1;  s00_axi_arready  out  1  read address handshake.
- s00_axi_rid / rdata / rresp / rlast / ruser  out  ID/DATA/2/1/RUSER  read beat: arid, word, 2'b00, final-beat flag, zero.
- s00_axi_rvalid  out  1;  s00_axi_rready  in  1  read data handshake.

Behaviour:
- Reset (aresetn=0, async): all outputs 0, both FSMs idle, counters cleared. Memory contents are not cleared.
- Reset asserted mid-burst aborts the burst immediately. No response is issued.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. Handshake latches awid, awaddr, awlen, awburst and clears the beat counter. Next cycle is W_DATA, awready=0.
  - W_DATA: wready=1. Each wvalid&wready beat writes wdata to word addr[ADDR-1:2], byte lanes gated by wstrb.
  - After awlen+1 beats: wready=0, go to W_RESP. wlast is not checked.
  - W_RESP: bvalid=1, bid=latched awid, bresp=OKAY. bvalid holds until bready. No new AW is accepted until the response completes.
  - wvalid asserted before the AW handshake is held off (wready=0).
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. Handshake latches arid, araddr, arlen, arburst.
  - R_DATA: rvalid=1 from the second cycle after the handshake (1-cycle RAM latency).
  - rdata/rid/rlast hold stable while rvalid=1 and rready=0.
  - rlast=1 on beat arlen. The rvalid&rready handshake on that beat returns to R_IDLE.
- Beat address update (both channels), all beats full-width regardless of awsize/arsize:
  - FIXED (00): address unchanged.
  - INCR (01): word index +1, wrapping modulo memory size at the top of memory.
  - WRAP (10): wraps within a (len+1)*4-byte aligned window.
  - 11: treated as INCR.
  - The low 2 address bits are ignored (word-aligned).
- Simultaneous read and write to the same word in the same cycle: the read returns the old data.
- Responses are always OKAY. No out-of-range error exists because the address decode is full.

Test Plan:
- Reset low 2 ns, then high -> all outputs 0 during reset; awready=1 and arready=1 on the first clock after release.
- AW: addr=3, len=7, INCR, id=0, pulsed 1 cycle; then wvalid=1, wdata=32'h12345678, wstrb=4'hF, wlast=0 -> 8 beats accepted at words 0..7. wready drops after beat 8. bvalid=1 with bid=0, bresp=0, held while bready=0. awready stays 0.
- Then bready=1 -> bvalid clears next cycle; awready=1 again.
- AR: addr=0, len=7, INCR, rready=1 -> 8 beats of 32'h12345678, rlast only on the 8th beat, rid=0.
- Write wstrb=4'b0011, wdata=32'hAABBCCDD to word 0, then read it back -> 32'h1234CCDD. Read with rready toggling -> data held stable.
- INCR burst from byte address 0x1FFC, len=1 -> second beat hits word 0. WRAP len=3 from 0x8 -> word order 2,3,0,1.
